// File: rtl/ksa_pkg.sv
// Shared constants, state codes and helpers for the RC4 key-scheduling loop.
package ksa_pkg;

    localparam int         N_BYTES     = 256;
    localparam int         KEY_BYTES   = 3;
    localparam logic [7:0] LAST_I      = 8'(N_BYTES - 1);
    localparam int         ITER_CYCLES = 9;

    typedef logic [3:0] ksa_state_t;

    localparam ksa_state_t ST_IDLE    = 4'd0;
    localparam ksa_state_t ST_READ_I  = 4'd1;
    localparam ksa_state_t ST_WAIT_I  = 4'd2;
    localparam ksa_state_t ST_LATCH_I = 4'd3;
    localparam ksa_state_t ST_READ_J  = 4'd4;
    localparam ksa_state_t ST_WAIT_J  = 4'd5;
    localparam ksa_state_t ST_LATCH_J = 4'd6;
    localparam ksa_state_t ST_WRITE_I = 4'd7;
    localparam ksa_state_t ST_WRITE_J = 4'd8;
    localparam ksa_state_t ST_DONE    = 4'd9;

    function automatic logic [1:0] next_kidx(input logic [1:0] k);
        return (k == 2'(KEY_BYTES - 1)) ? 2'd0 : k + 2'd1;
    endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// Selects key byte kidx from the 24-bit secret key; byte 0 is the MSB.
module ksa_key_sel
    import ksa_pkg::*;
(
    input  logic [23:0] secret_key,
    input  logic [1:0]  kidx,
    output logic [7:0]  key_byte
);

    always_comb begin
        key_byte = secret_key[7:0];
        case (kidx)
            2'd0:    key_byte = secret_key[23:16];
            2'd1:    key_byte = secret_key[15:8];
            default: key_byte = secret_key[7:0];
        endcase
    end

endmodule

// File: rtl/ksa_loop.sv
// RC4 key-scheduling (second loop) engine driving a single-port S memory.
// Optional KSA_SAME_SKIP_EN: skip the j-read and both writes when new j == i.
//
// state    | meaning
// IDLE     | waiting for start
// READ_I   | address = i
// WAIT_I   | memory read latency
// LATCH_I  | capture s[i], update j
// READ_J   | two cycles: load address from the j register, then present it
// WAIT_J   | memory read latency
// LATCH_J  | capture s[j] into the write-data register
// WRITE_I  | s[i] <= s[j]
// WRITE_J  | s[j] <= s[i], then advance i or finish
// DONE     | done high until start drops
module ksa_loop
    import ksa_pkg::*;
(
    input  logic        clok,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    output logic [7:0]  address,
    output logic [7:0]  data,
    output logic        wren,
    input  logic [7:0]  q,
    output logic        busy,
    output logic        done
);

    ksa_state_t  state;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [1:0]  kidx;
    logic [7:0]  si;
    logic        rdj_armed;
    logic [7:0]  key_byte;
    logic [7:0]  j_sum;

    ksa_key_sel u_key_sel (
        .secret_key (secret_key),
        .kidx       (kidx),
        .key_byte   (key_byte)
    );

    assign j_sum = j + q + key_byte;

    always_ff @(posedge clok or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            kidx      <= '0;
            si        <= '0;
            rdj_armed <= 1'b0;
            address   <= '0;
            data      <= '0;
            wren      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        i       <= '0;
                        j       <= '0;
                        kidx    <= '0;
                        address <= '0;
                        busy    <= 1'b1;
                        state   <= ST_READ_I;
                    end
                end
                ST_READ_I: state <= ST_WAIT_I;
                ST_WAIT_I: state <= ST_LATCH_I;
                ST_LATCH_I: begin
                    si        <= q;
                    j         <= j_sum;
                    rdj_armed <= 1'b0;
`ifdef KSA_SAME_SKIP_EN
                    if (j_sum == i) begin
                        if (i == LAST_I) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            i       <= i + 8'd1;
                            kidx    <= next_kidx(kidx);
                            address <= i + 8'd1;
                            state   <= ST_READ_I;
                        end
                    end else begin
                        state <= ST_READ_J;
                    end
`else
                    state <= ST_READ_J;
`endif
                end
                // j is loaded from its register, keeping the 3-input add off the address flop
                ST_READ_J: begin
                    if (!rdj_armed) begin
                        rdj_armed <= 1'b1;
                        address   <= j;
                    end else begin
                        state <= ST_WAIT_J;
                    end
                end
                ST_WAIT_J: state <= ST_LATCH_J;
                ST_LATCH_J: begin
                    data    <= q;
                    address <= i;
                    wren    <= 1'b1;
                    state   <= ST_WRITE_I;
                end
                ST_WRITE_I: begin
                    data    <= si;
                    address <= j;
                    state   <= ST_WRITE_J;
                end
                ST_WRITE_J: begin
                    wren <= 1'b0;
                    if (i == LAST_I) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        i       <= i + 8'd1;
                        kidx    <= next_kidx(kidx);
                        address <= i + 8'd1;
                        state   <= ST_READ_I;
                    end
                end
                ST_DONE: begin
                    wren <= 1'b0;
                    if (!start) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_loop.sv
// Self-checking bench for ksa_loop: registered-output S memory model and a plain RC4 KSA reference.
module tb_ksa_loop;

    logic        clok = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic [7:0]  q = 8'd0;
    logic        busy;
    logic        done;

    ksa_loop dut (
        .clok       (clok),
        .rst_n      (rst_n),
        .start      (start),
        .secret_key (secret_key),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    always #5 clok = ~clok;

    logic [7:0] mem [256];
    logic [7:0] pre_img [256];
    logic       pre_req = 1'b0;
    logic [7:0] mem_addr_q = 8'd0;

    // single-port memory with registered address and registered output
    always @(posedge clok) begin
        if (pre_req) mem <= pre_img;
        else if (wren) mem[address] <= data;
        mem_addr_q <= address;
        q <= mem[mem_addr_q];
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_wr[$];
    logic [15:0] cap_wr[$];
    logic [7:0]  exp_s [256];

    typedef struct {
        logic [23:0] key;
        int          widx;
        logic [7:0]  addr;
        logic [7:0]  wdata;
    } wr_vec_t;

    wr_vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input bit identity);
        for (int k = 0; k < 256; k++)
            pre_img[k] = identity ? 8'(k) : 8'($urandom_range(0, 255));
        pre_req = 1'b1;
        @(posedge clok);
        #1 pre_req = 1'b0;
        @(negedge clok);
    endtask

    task automatic build_golden(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] t;
        int jj;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int k = 0; k < 256; k++) s[k] = mem[k];
        exp_wr.delete();
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + int'(s[ii]) + int'(kb[ii % 3])) % 256;
            exp_wr.push_back({8'(ii), s[jj]});
            exp_wr.push_back({8'(jj), s[ii]});
            t = s[ii];
            s[ii] = s[jj];
            s[jj] = t;
        end
        for (int k = 0; k < 256; k++) exp_s[k] = s[k];
    endtask

    task automatic do_run(input logic [23:0] key, input bit pulse, input int hold_after);
        int cyc;
        int busy_cyc;
        int wren_cyc;
        int bad;
        int n;
        secret_key = key;
        build_golden(key);
        cap_wr.delete();
        cyc = 0;
        busy_cyc = 0;
        wren_cyc = 0;
        start = 1'b1;
        do begin
            @(negedge clok);
            cyc++;
            if (pulse && cyc == 1) start = 1'b0;
            if (busy) busy_cyc++;
            if (wren) begin
                wren_cyc++;
                cap_wr.push_back({address, data});
            end
        end while (!done && cyc < 3000);
        chk("done_seen", 32'(done), 32'd1);
        chk("done_cycle", 32'(cyc), 32'd2305);
        chk("busy_cycles", 32'(busy_cyc), 32'd2304);
        chk("wren_cycles", 32'(wren_cyc), 32'd512);
        chk("wr_count", 32'(cap_wr.size()), 32'(exp_wr.size()));
        n = (cap_wr.size() < exp_wr.size()) ? cap_wr.size() : exp_wr.size();
        bad = 0;
        for (int k = 0; k < n; k++) if (cap_wr[k] !== exp_wr[k]) bad++;
        chk("wr_sequence", 32'(bad), 32'd0);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) bad++;
        chk("final_s", 32'(bad), 32'd0);
        if (pulse) begin
            @(negedge clok);
            chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
        end else begin
            bad = 0;
            for (int k = 0; k < hold_after; k++) begin
                @(negedge clok);
                if (!done || busy || wren) bad++;
            end
            if (hold_after > 0) chk("hold_after_done", 32'(bad), 32'd0);
            start = 1'b0;
            @(negedge clok);
            chk("done_drop", {30'd0, done, busy}, 32'd0);
        end
    endtask

    task automatic check_table(input logic [23:0] key);
        foreach (tbl[r]) begin
            if (tbl[r].key == key) begin
                chk("tbl_have_write", 32'(cap_wr.size() > tbl[r].widx), 32'd1);
                if (cap_wr.size() > tbl[r].widx)
                    chk($sformatf("tbl_k%06h_w%0d", key, tbl[r].widx),
                        32'(cap_wr[tbl[r].widx]), {16'd0, tbl[r].addr, tbl[r].wdata});
            end
        end
    endtask

    initial begin
        int wcount;
        logic [23:0] rkey;

        tbl[0]  = '{24'h000000, 0, 8'd0, 8'd0};
        tbl[1]  = '{24'h000000, 1, 8'd0, 8'd0};
        tbl[2]  = '{24'h000000, 2, 8'd1, 8'd1};
        tbl[3]  = '{24'h000000, 3, 8'd1, 8'd1};
        tbl[4]  = '{24'h000000, 4, 8'd2, 8'd3};
        tbl[5]  = '{24'h000000, 5, 8'd3, 8'd2};
        tbl[6]  = '{24'h010203, 0, 8'd0, 8'd1};
        tbl[7]  = '{24'h010203, 1, 8'd1, 8'd0};
        tbl[8]  = '{24'h010203, 2, 8'd1, 8'd3};
        tbl[9]  = '{24'h010203, 3, 8'd3, 8'd0};
        tbl[10] = '{24'h010203, 4, 8'd2, 8'd8};
        tbl[11] = '{24'h010203, 5, 8'd8, 8'd2};

        rst_n = 1'b0;
        start = 1'b0;
        secret_key = 24'h0;
        repeat (3) @(negedge clok);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clok);
        chk("idle_no_start", {29'd0, busy, wren, done}, 32'd0);

        // zero key, start held 20 cycles past done
        preload(1'b1);
        do_run(24'h000000, 1'b0, 20);
        check_table(24'h000000);

        // restart from identity after the held-start run
        preload(1'b1);
        do_run(24'h000249, 1'b0, 0);

        // one-cycle start pulse
        preload(1'b1);
        do_run(24'h010203, 1'b1, 0);
        check_table(24'h010203);

        for (int r = 0; r < 2; r++) begin
            preload(1'b0);
            do_run(24'($urandom), 1'b0, 0);
        end

        // reset in WRITE_I of iteration 40
        preload(1'b1);
        rkey = 24'($urandom);
        secret_key = rkey;
        start = 1'b1;
        wcount = 0;
        for (int c = 0; c < 1000 && wcount < 81; c++) begin
            @(negedge clok);
            if (wren) wcount++;
        end
        chk("reach_i40_write", 32'(wcount), 32'd81);
        chk("pre_rst_addr", 32'(address), 32'd40);
        rst_n = 1'b0;
        #1;
        chk("midrst_address", 32'(address), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_wren", 32'(wren), 32'd0);
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clok);
        start = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clok);
            chk("idle_after_rst", {29'd0, busy, wren, done}, 32'd0);
        end
        do_run(rkey, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
